// File: rtl/dram_lsu_if.sv
// Request/response bundle between the pipeline MEM stage (master) and the data memory (slave).
interface dram_lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_uns_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rd_data_o;
  logic        misalign_o;
  logic        busy_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_uns_i, addr_i, wr_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rd_data_o, misalign_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_uns_i, addr_i, wr_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rd_data_o, misalign_o, busy_o
  );
endinterface

// File: rtl/dram_lsu.sv
// Data memory with a RISC-V load/store front end: byte-lane stores, sign/zero-extended loads,
// misalignment flagging, and an RD_LAT-deep stallable response pipeline.
module dram_lsu #(
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1,
  parameter     INIT_FILE = ""
) (
  input  logic      clk,
  input  logic      rst,
  dram_lsu_if.slave bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int WORDS = 2 ** IDX_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
  // a response transfers where rsp_valid_o && rsp_ready_i. The whole pipeline advances
  // only when the last stage is empty or being taken, so a stalled response never changes.

  logic [31:0]      r_mem [WORDS];
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_mis;
  logic [31:0]      r_data [RD_LAT];

  logic             w_adv;
  logic             w_ready;
  logic             w_accept;
  logic             w_mis;
  logic             w_wr_en;
  logic [3:0]       w_mask;
  logic [31:0]      w_wdata;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rword;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ld_data;

  if (ADDR_W < 32) begin : g_hi_addr
    logic w_unused_hi;
    assign w_unused_hi = |bus.addr_i[31:ADDR_W];
  end

  assign w_adv    = !r_vld[RD_LAT-1] || bus.rsp_ready_i;
  assign w_ready  = w_adv && !rst;
  assign w_accept = bus.req_valid_i && w_ready;
  assign w_idx    = bus.addr_i[ADDR_W-1:2];
  assign w_rword  = r_mem[w_idx];
  assign w_wr_en  = w_accept && bus.req_we_i && !w_mis;

  // Misalignment and store lane mask both derive from size and the low address bits.
  always_comb begin
    w_mis  = 1'b0;
    w_mask = 4'b0000;
    case (bus.req_size_i)
      SZ_BYTE: w_mask = 4'b0001 << bus.addr_i[1:0];
      SZ_HALF: begin
        w_mis  = bus.addr_i[0];
        w_mask = 4'b0011 << bus.addr_i[1:0];
      end
      SZ_WORD: begin
        w_mis  = (bus.addr_i[1:0] != 2'b00);
        w_mask = 4'b1111;
      end
      default: w_mis = 1'b1;
    endcase
  end

  always_comb begin
    w_wdata = bus.wr_data_i;
    case (bus.req_size_i)
      SZ_BYTE: w_wdata = {4{bus.wr_data_i[7:0]}};
      SZ_HALF: w_wdata = {2{bus.wr_data_i[15:0]}};
      default: w_wdata = bus.wr_data_i;
    endcase
  end

  always_comb begin
    w_byte = w_rword[7:0];
    case (bus.addr_i[1:0])
      2'd0:    w_byte = w_rword[7:0];
      2'd1:    w_byte = w_rword[15:8];
      2'd2:    w_byte = w_rword[23:16];
      default: w_byte = w_rword[31:24];
    endcase
    w_half = bus.addr_i[1] ? w_rword[31:16] : w_rword[15:0];
  end

  // Stores and misaligned requests still produce a response, carrying zero data.
  always_comb begin
    w_ld_data = 32'h0;
    if (!bus.req_we_i && !w_mis) begin
      case (bus.req_size_i)
        SZ_BYTE: w_ld_data = bus.req_uns_i ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        SZ_HALF: w_ld_data = bus.req_uns_i ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        SZ_WORD: w_ld_data = w_rword;
        default: w_ld_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_mis <= '0;
      for (int i = 0; i < RD_LAT; i++) r_data[i] <= 32'h0;
    end else if (w_adv) begin
      r_vld[0]  <= w_accept;
      r_mis[0]  <= w_accept && w_mis;
      r_data[0] <= w_accept ? w_ld_data : 32'h0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_mis[i]  <= r_mis[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.rsp_valid_o = r_vld[RD_LAT-1];
  assign bus.rd_data_o   = r_data[RD_LAT-1];
  assign bus.misalign_o  = r_mis[RD_LAT-1];
  assign bus.busy_o      = |r_vld;
endmodule
